cdpga_rst_seq: RTL and testbench

//  Reset sequencer for the PLL that turns 16 MHz into 40 MHz. Runs on the 16 MHz reference clock.

---
 rtl/cdpga_rst_seq_pkg.sv | 16 +
 rtl/cdpga_rst_seq_if.sv | 20 ++
 rtl/cdpga_rst_seq_sync.sv | 19 +
 rtl/cdpga_rst_seq.sv | 125 ++++++++++++
 tb/tb_cdpga_rst_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cdpga_rst_seq_pkg.sv
// cdpga_rst_seq_pkg: shared state encoding, counter width and saturating increment for the PLL reset sequencer
// Contents:
//   state_t  sequencer states; 2'd3 is unused and recovers to ST_PLL_RST
//   CNT_W    width of the saturating event counters
//   sat_inc  increment that holds at all-ones instead of wrapping
package cdpga_rst_seq_pkg;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } state_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/cdpga_rst_seq_if.sv
// cdpga_rst_seq_if: PLL-facing and system-facing signals of the reset sequencer
// Signals:
//   pll_lock       PLL LOCK output, asynchronous to clk
//   pll_resetb     PLL RESET input, active low
//   sys_rst        active-high system reset request
//   ready          high while the sequencer is in RUN
//   lock_loss_cnt  saturating count of lock losses seen in RUN
//   retry_cnt      saturating count of lock-timeout retries
// Modports: master = sequencer side, slave = PLL/system side
interface cdpga_rst_seq_if;
    import cdpga_rst_seq_pkg::*;
    logic             pll_lock;
    logic             pll_resetb;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] retry_cnt;
    modport master (input pll_lock, output pll_resetb, sys_rst, ready, lock_loss_cnt, retry_cnt);
    modport slave (output pll_lock, input pll_resetb, sys_rst, ready, lock_loss_cnt, retry_cnt);
endinterface

// File: rtl/cdpga_rst_seq_sync.sv
// cdpga_sync: STAGES-deep flop synchronizer with synchronous reset to 0
// Ports:
//   clk  destination clock
//   rst  synchronous active-high reset, clears every stage
//   d    asynchronous input
//   q    synchronized output
module cdpga_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk)
        ff <= rst ? '0 : {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/cdpga_rst_seq.sv
// cdpga_rst_seq: PLL reset sequencer; holds the PLL in reset, waits for stable lock, then releases system reset
// Ports:
//   clk  16 MHz reference clock (same net as the PLL reference)
//   rst  synchronous active-high reset
//   bus  cdpga_rst_seq_if.master: pll_lock in; pll_resetb, sys_rst, ready, lock_loss_cnt, retry_cnt out
// Build option CDPGA_RST_SEQ_RETRY_EN: adds a WAIT_LOCK timeout that re-pulses the PLL reset and counts retries;
// without it WAIT_LOCK waits indefinitely and retry_cnt is 0.
module cdpga_rst_seq
    import cdpga_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 16000,
    parameter int SYNC_STAGES        = 2
) (
    input logic            clk,
    input logic            rst,
    cdpga_rst_seq_if.master bus
);
    localparam int RW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    if (PLL_RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT < 1 || SYNC_STAGES < 2) begin : g_bad_param
        $error("cdpga_rst_seq: parameter below its minimum");
    end
    state_t           state;
    logic [RW-1:0]    rst_tmr;
    logic [SW-1:0]    stable;
    logic             lock_s;
    logic             pll_resetb;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic             rst_done;
    logic             stable_hit;
    cdpga_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (bus.pll_lock),
        .q  (lock_s)
    );
    assign rst_done   = rst_tmr == RW'(PLL_RST_CYCLES - 1);
    assign stable_hit = lock_s && stable == SW'(LOCK_STABLE_CYCLES - 1);
`ifdef CDPGA_RST_SEQ_RETRY_EN
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    logic [TW-1:0]    tout;
    logic [CNT_W-1:0] retry_cnt;
    logic             tout_hit;
    assign tout_hit      = tout == TW'(LOCK_TIMEOUT - 1);
    assign bus.retry_cnt = retry_cnt;
`else
    assign bus.retry_cnt = '0;
`endif
    // Outputs are updated on the same edge as the state change so they always match the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_PLL_RST;
            rst_tmr       <= '0;
            stable        <= '0;
            pll_resetb    <= 1'b0;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
`ifdef CDPGA_RST_SEQ_RETRY_EN
            tout          <= '0;
            retry_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_PLL_RST: begin
                    rst_tmr <= rst_done ? '0 : rst_tmr + 1'b1;
                    if (rst_done) begin
                        state      <= ST_WAIT_LOCK;
                        pll_resetb <= 1'b1;
                        stable     <= '0;
`ifdef CDPGA_RST_SEQ_RETRY_EN
                        tout       <= '0;
`endif
                    end
                end
                ST_WAIT_LOCK: begin
                    // Any low sample of lock_s restarts the stability window.
                    stable <= (lock_s && !stable_hit) ? stable + 1'b1 : '0;
`ifdef CDPGA_RST_SEQ_RETRY_EN
                    tout   <= tout + 1'b1;
`endif
                    if (stable_hit) begin
                        state   <= ST_RUN;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end
`ifdef CDPGA_RST_SEQ_RETRY_EN
                    // Stability is tested first, so a simultaneous timeout still releases.
                    else if (tout_hit) begin
                        state      <= ST_PLL_RST;
                        pll_resetb <= 1'b0;
                        rst_tmr    <= '0;
                        retry_cnt  <= sat_inc(retry_cnt);
                    end
`endif
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state         <= ST_PLL_RST;
                        pll_resetb    <= 1'b0;
                        sys_rst       <= 1'b1;
                        ready         <= 1'b0;
                        rst_tmr       <= '0;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end
                end
                default: begin
                    state      <= ST_PLL_RST;
                    pll_resetb <= 1'b0;
                    sys_rst    <= 1'b1;
                    ready      <= 1'b0;
                    rst_tmr    <= '0;
                end
            endcase
        end
    end
    assign bus.pll_resetb    = pll_resetb;
    assign bus.sys_rst       = sys_rst;
    assign bus.ready         = ready;
    assign bus.lock_loss_cnt = lock_loss_cnt;
endmodule

// File: tb/tb_cdpga_rst_seq.sv
// tb_cdpga_rst_seq: self-checking bench for cdpga_rst_seq against a cycle-level behavioural model
module tb_cdpga_rst_seq;
    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int TO   = 32;
    localparam int SYNC = 2;
`ifdef CDPGA_RST_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    cdpga_rst_seq_if bus ();
    cdpga_rst_seq #(
        .PLL_RST_CYCLES    (PRC),
        .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT      (TO),
        .SYNC_STAGES       (SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: time left in PLL reset, whether running, and how many consecutive
    // synchronized-high samples / waiting cycles have been seen.
    bit hist [SYNC];
    int m_left, m_good, m_wait, m_loss, m_retry;
    bit m_run, chk_en = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_left = PRC; m_good = 0; m_wait = 0; m_loss = 0; m_retry = 0; m_run = 1'b0;
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            chk_en = 1'b1;
        end else begin
            bit ls;
            ls = hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.pll_lock;
            if (m_left > 0) begin
                m_left--; m_good = 0; m_wait = 0;
            end else if (m_run) begin
                if (!ls) begin
                    m_run = 1'b0; m_left = PRC; m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                end
            end else begin
                m_good = ls ? m_good + 1 : 0;
                m_wait++;
                if (m_good == LSC) m_run = 1'b1;
                else if (RETRY && m_wait == TO) begin
                    m_left = PRC; m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            check("pll_resetb", int'(bus.pll_resetb), int'(m_left == 0));
            check("sys_rst", int'(bus.sys_rst), int'(!m_run));
            check("ready", int'(bus.ready), int'(m_run));
            check("lock_loss_cnt", int'(bus.lock_loss_cnt), m_loss);
            check("retry_cnt", int'(bus.retry_cnt), m_retry);
        end
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    function automatic logic sig(input int which);
        return (which == 0) ? bus.pll_resetb : bus.sys_rst;
    endfunction
    task automatic wait_for(input int which, input logic lvl, input int lim, output int n);
        n = 0;
        while (sig(which) !== lvl && n < lim) begin
            step();
            n++;
        end
    endtask
    task automatic do_reset;
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask
    task automatic lose_lock(output int n);
        bus.pll_lock = 1'b0;
        step();
        bus.pll_lock = 1'b1;
        step();
        step();
        wait_for(1, 1'b0, 100, n);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        bus.pll_lock = 1'b0;
        // 1: power-up; the PLL reports lock as soon as its reset is released
        do_reset();
        wait_for(0, 1'b1, 50, n);
        check("t1_resetb_low_cycles", n, 4);
        bus.pll_lock = 1'b1;
        wait_for(1, 1'b0, 100, n);
        check("t1_release_latency", n, 10);
        check("t1_ready", int'(bus.ready), 1);
        // 2: one-cycle glitch while waiting for lock
        do_reset();
        wait_for(0, 1'b1, 50, n);
        bus.pll_lock = 1'b1;
        repeat (5) step();
        bus.pll_lock = 1'b0;
        step();
        bus.pll_lock = 1'b1;
        wait_for(1, 1'b0, 100, n);
        check("t2_release_after_reraise", n, 10);
        check("t2_lock_loss_cnt", int'(bus.lock_loss_cnt), 0);
        // 3: lock loss while running
        bus.pll_lock = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            bus.pll_lock = 1'b1;
        end while (!bus.sys_rst && n < 20);
        check("t3_loss_edges", n, 3);
        check("t3_lock_loss_cnt", int'(bus.lock_loss_cnt), 1);
        check("t3_resetb_low", int'(bus.pll_resetb), 0);
        wait_for(0, 1'b1, 50, n);
        check("t3_resetb_low_cycles", n, 4);
        wait_for(1, 1'b0, 100, n);
        check("t3_relock_cycles", n, 8);
        // 4: counter saturation
        for (int i = 1; i < 300; i++) lose_lock(n);
        check("t4_lock_loss_sat", int'(bus.lock_loss_cnt), 255);
        // 5: lock never arrives
        do_reset();
        wait_for(0, 1'b1, 50, n);
        check("t5_first_pulse", n, 4);
        wait_for(0, 1'b0, 100, n);
`ifdef CDPGA_RST_SEQ_RETRY_EN
        check("t5_timeout_cycles", n, 32);
        check("t5_retry_1", int'(bus.retry_cnt), 1);
        wait_for(0, 1'b1, 50, n);
        check("t5_retry_pulse", n, 4);
        wait_for(0, 1'b0, 100, n);
        check("t5_timeout_cycles_2", n, 32);
        check("t5_retry_2", int'(bus.retry_cnt), 2);
`else
        check("t5_no_retry_wait", n, 100);
        check("t5_retry_zero", int'(bus.retry_cnt), 0);
`endif
        // 6: reset while running clears everything on the next edge
        bus.pll_lock = 1'b1;
        wait_for(1, 1'b0, 200, n);
        lose_lock(n);
        check("t6_in_run", int'(bus.ready), 1);
        check("t6_loss_before", int'(bus.lock_loss_cnt), 1);
        rst = 1'b1;
        step();
        check("t6_resetb", int'(bus.pll_resetb), 0);
        check("t6_sys_rst", int'(bus.sys_rst), 1);
        check("t6_ready", int'(bus.ready), 0);
        check("t6_loss_cnt", int'(bus.lock_loss_cnt), 0);
        check("t6_retry_cnt", int'(bus.retry_cnt), 0);
        rst = 1'b0;
        repeat (20) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
